systb_filter_ctrl: RTL
======================

# systb_filter_ctrl

Sequencing and trigger controller for one two-lane systB matched-filter datapath (INBITS=12, OUTBITS=16, two SIMD lanes per DSP chain).
- Gates the input stream to zero while idle and blanks the filter outputs until the DSP cascade has filled.
- Compares both lane outputs against a programmable magnitude threshold.
- Issues trigger pulses with a holdoff window.
- Sits between the register/config interface and the filter bank; it owns the run/idle sequencing and the trigger decision for that bank.

## Interface
Parameters:
- OUTBITS, 16: signed filter output width per lane.
- FILL_CYCLES, 6: cascade latency from first live input to first valid output; range 1..63.
- HOLDOFF_CYCLES, 16: cycles after a trigger during which no new trigger may fire; range 1..1023.
- THRESH_DEFAULT, 16'd1000: threshold value after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- run_i  in  1  level; 1 = filter running.
- thresh_i  in  OUTBITS  unsigned threshold candidate.
- thresh_wr_i  in  1  one-cycle pulse; loads thresh_i into the pending register.
- out0_i, out1_i  in  OUTBITS each  signed filter lane outputs.
- flush_o  out  1  1 = datapath inputs forced to zero.
- dat_valid_o  out  1  filter outputs are meaningful.
- thresh_ack_o  out  1  one-cycle pulse when the pending threshold becomes active.
- trig_o  out  1  one-cycle trigger pulse.
- trig_mask_o  out  2  lanes exceeding threshold; bit0 = lane 0.
- trig_count_o  out  16  saturating trigger count.

## Operation
- FSM states: IDLE, FILL, RUN, HOLDOFF.
  - IDLE: flush_o=1. Leaves to FILL when run_i=1.
  - FILL: counts FILL_CYCLES cycles, then goes to RUN.
  - RUN: evaluates the trigger condition every cycle.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, then returns to RUN.
  - From any non-IDLE state, run_i=0 goes to IDLE on the next edge, discarding the fill and holdoff counts.
- Magnitude: mag = |x| as OUTBITS-bit unsigned. The most negative input maps to 2^(OUTBITS-1) exactly, with no saturation.
- Lane n exceeds when mag_n > active threshold (strict compare). A threshold of 0 fires on any nonzero sample.
- Trigger:
  - Condition: state RUN and at least one lane exceeds.
  - Response: trig_o=1 with trig_mask_o showing all exceeding lanes; both lanes may be set simultaneously.
  - The FSM then enters HOLDOFF.
- Exceedances in FILL, HOLDOFF or IDLE are ignored. They are not latched.
- trig_count_o:
  - Increments per trigger and saturates at 0xFFFF.
  - Clears on the IDLE→FILL transition.
  - Holds its value in IDLE.
- Threshold update:
  - thresh_wr_i loads pending and sets a pending flag.
  - A second write before application overwrites pending.
  - Pending is applied on the first cycle the FSM is not in HOLDOFF; thresh_ack_o pulses in that cycle.
  - A write arriving during HOLDOFF is applied on the first RUN cycle after the holdoff.
- Reset values: state IDLE; flush_o=1; all other outputs 0; active threshold = THRESH_DEFAULT; pending flag clear; trig_count_o=0.
- Reset mid-operation returns everything to the reset values on the next edge. Any pending threshold is lost.

## Timing
- All outputs are registered.
- run_i sampled 1 at edge k:
  - flush_o=0 from edge k+1.
  - dat_valid_o=1 from edge k+1+FILL_CYCLES.
- dat_valid_o=1 in RUN and HOLDOFF.
- Trigger latency: out*_i exceeding at edge t (state RUN) gives trig_o=1 after edge t+1, for exactly one cycle.
  - The state is HOLDOFF for edges t+1 .. t+HOLDOFF_CYCLES.
  - The earliest next trigger uses samples at edge t+HOLDOFF_CYCLES+1.
- run_i sampled 0 at edge k: flush_o=1 and dat_valid_o=0 after edge k+1. A trigger decided from the sample at edge k still issues.
- thresh_wr_i at edge w with state not HOLDOFF: the new threshold governs compares from samples at edge w+2; thresh_ack_o is high after edge w+1.
- Simultaneous thresh_wr_i and a trigger-qualifying sample: the compare uses the old threshold.

## Structure
- Shared package holds:
  - the state enum: IDLE, FILL, RUN, HOLDOFF;
  - the OUTBITS default;
  - the FILL_CYCLES default constant, so the filter bank and controller agree on cascade latency.
- One natural sub-module: systb_lane_mag_cmp. It is combinational per lane (abs + strict compare) and is instantiated twice.
- Counters: fill/holdoff share one 10-bit down-counter.

## Test plan
- Reset, then run_i=1 at edge 10 → flush_o falls after edge 11; dat_valid_o rises after edge 17 (FILL_CYCLES=6); no trig_o during FILL even with out0_i=0x7FFF.
- RUN, threshold 1000, out0_i=1001, out1_i=-1001 for one cycle → one trig_o, trig_mask_o=2'b11, trig_count_o=1; out0_i=1000 alone → no trigger.
- out1_i=-32768 with threshold 32767 → trigger, mask 2'b10; sustained exceedance for 40 cycles → triggers spaced exactly 17 cycles apart (HOLDOFF_CYCLES=16).
- thresh_wr_i=500 during HOLDOFF → thresh_ack_o only on the first RUN cycle after the holdoff; out0_i=600 triggers afterwards, never during the holdoff.
- run_i dropped in HOLDOFF, then reasserted → IDLE for one or more cycles, refill of 6 cycles, trig_count_o cleared to 0; rst_i mid-RUN → all outputs at reset values next cycle, threshold back to 1000.

Source files
------------

// File: rtl/systb_filter_ctrl_pkg.sv
// Shared definitions for the systB filter bank and its sequencing controller.
// The fill latency lives here so the bank and controller agree on cascade depth.
package systb_filter_ctrl_pkg;
    localparam int OUTBITS_DEF     = 16;
    localparam int FILL_CYCLES_DEF = 6;
    localparam int CNT_W           = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        RUN     = 2'd2,
        HOLDOFF = 2'd3
    } ctrl_state_t;
endpackage

// File: rtl/systb_lane_mag_cmp.sv
// Per-lane magnitude and strict threshold compare, purely combinational.
// The most negative input maps to 2^(OUTBITS-1) without saturating.
module systb_lane_mag_cmp #(
    parameter int OUTBITS = 16
) (
    input  logic [OUTBITS-1:0] dat,
    input  logic [OUTBITS-1:0] thresh,
    output logic               exceed
);
    logic [OUTBITS-1:0] mag;

    assign mag    = dat[OUTBITS-1] ? ((~dat) + OUTBITS'(1)) : dat;
    assign exceed = (mag > thresh);
endmodule

// File: rtl/systb_filter_ctrl.sv
// Run/idle sequencing, fill blanking and holdoff-gated trigger decision for
// one two-lane systB matched-filter bank.
module systb_filter_ctrl
    import systb_filter_ctrl_pkg::*;
#(
    parameter int                 OUTBITS        = OUTBITS_DEF,
    parameter int                 FILL_CYCLES    = FILL_CYCLES_DEF,
    parameter int                 HOLDOFF_CYCLES = 16,
    parameter logic [OUTBITS-1:0] THRESH_DEFAULT = OUTBITS'(1000)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               run_i,
    input  logic [OUTBITS-1:0] thresh_i,
    input  logic               thresh_wr_i,
    input  logic [OUTBITS-1:0] out0_i,
    input  logic [OUTBITS-1:0] out1_i,
    output logic               flush_o,
    output logic               dat_valid_o,
    output logic               thresh_ack_o,
    output logic               trig_o,
    output logic [1:0]         trig_mask_o,
    output logic [15:0]        trig_count_o
);
    localparam int NUM_LANES = 2;

    ctrl_state_t                        state;
    logic [CNT_W-1:0]                   cnt;
    logic [OUTBITS-1:0]                 thresh_act;
    logic [OUTBITS-1:0]                 thresh_pend;
    logic                               pend_vld;
    logic [NUM_LANES-1:0][OUTBITS-1:0]  lane_dat;
    logic [NUM_LANES-1:0]               exceed;
    logic                               apply;
    logic                               fire;

    assign lane_dat = {out1_i, out0_i};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        systb_lane_mag_cmp #(.OUTBITS(OUTBITS)) u_cmp (
            .dat    (lane_dat[l]),
            .thresh (thresh_act),
            .exceed (exceed[l])
        );
    end

    // Pending threshold never lands mid-holdoff so a holdoff window is judged
    // against one threshold; a trigger sample always uses the threshold in force.
    assign apply = pend_vld && (state != HOLDOFF);
    assign fire  = (state == RUN) && (|exceed);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            thresh_act   <= THRESH_DEFAULT;
            thresh_pend  <= '0;
            pend_vld     <= 1'b0;
            flush_o      <= 1'b1;
            dat_valid_o  <= 1'b0;
            thresh_ack_o <= 1'b0;
            trig_o       <= 1'b0;
            trig_mask_o  <= '0;
            trig_count_o <= '0;
        end else begin
            trig_o       <= 1'b0;
            trig_mask_o  <= '0;
            thresh_ack_o <= 1'b0;

            if (apply) begin
                thresh_act   <= thresh_pend;
                thresh_ack_o <= 1'b1;
            end
            if (thresh_wr_i) begin
                thresh_pend <= thresh_i;
                pend_vld    <= 1'b1;
            end else if (apply) begin
                pend_vld    <= 1'b0;
            end

            // A trigger decided on the same edge run_i drops still issues.
            if (fire) begin
                trig_o      <= 1'b1;
                trig_mask_o <= exceed;
                if (trig_count_o != 16'hFFFF)
                    trig_count_o <= trig_count_o + 16'd1;
            end

            if (!run_i) begin
                state       <= IDLE;
                flush_o     <= 1'b1;
                dat_valid_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state        <= FILL;
                        cnt          <= CNT_W'(FILL_CYCLES - 1);
                        flush_o      <= 1'b0;
                        trig_count_o <= '0;
                    end
                    FILL: begin
                        if (cnt == '0) begin
                            state       <= RUN;
                            dat_valid_o <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    RUN: begin
                        if (fire) begin
                            state <= HOLDOFF;
                            cnt   <= CNT_W'(HOLDOFF_CYCLES - 1);
                        end
                    end
                    HOLDOFF: begin
                        if (cnt == '0) state <= RUN;
                        else           cnt   <= cnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
